// File: rtl/regfile_writeback_if.sv
// Result handshake between execute and the writeback queue.
// Producer drives valid/data/addr, the queue answers with ready.
interface regfile_writeback_if;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_addr;

  modport master (
    output res_valid,
    output res_data,
    output res_addr,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_addr,
    output res_ready
  );
endinterface

// File: rtl/regfile_writeback.sv
// In-order writeback queue feeding the 8x16 register file write port,
// with a pending-write scoreboard and youngest-match forwarding query.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  regfile_writeback_if.slave res,
  input  logic               wr_stall,
  output logic [15:0]        bus_w,
  output logic [2:0]         addr_w,
  output logic               en_w,
  input  logic [2:0]         q_addr,
  output logic               q_hit,
  output logic [15:0]        q_data,
  output logic [7:0]         pending,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [15:0]      ent_data [DEPTH];
  logic [2:0]       ent_addr [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (cnt == FULL);
  assign empty = (cnt == '0);
  assign push  = res.res_valid && !full;
  assign pop   = !empty && !wr_stall;

  assign res.res_ready = !full;
  assign en_w          = pop;
  assign bus_w         = empty ? 16'h0 : ent_data[rd_ptr];
  assign addr_w        = empty ? 3'h0 : ent_addr[rd_ptr];
  assign count         = cnt;

  // Queue pointers and occupancy; full/empty come from count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; push and pop never hit the same slot in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_data[i] <= '0;
        ent_addr[i] <= '0;
      end
      ent_vld <= '0;
    end else begin
      if (push) begin
        ent_data[wr_ptr] <= res.res_data;
        ent_addr[wr_ptr] <= res.res_addr;
        ent_vld[wr_ptr]  <= 1'b1;
      end
      if (pop) ent_vld[rd_ptr] <= 1'b0;
    end
  end

  // Scoreboard and forwarding; oldest-to-youngest walk so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    pending = '0;
    q_hit   = 1'b0;
    q_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (ent_vld[idx]) begin
        pending[ent_addr[idx]] = 1'b1;
        if (ent_addr[idx] == q_addr) begin
          q_hit  = 1'b1;
          q_data = ent_data[idx];
        end
      end
    end
  end

endmodule
